// File: rtl/instr_sequencer.sv
// Instruction sequencer: replays a loadable program into the 16-bit processor
// over its DIN/Run/Done handshake, one entry (plus optional immediate) at a time.
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          Resetn,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [16:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          busy,
  output logic          halted,
  output logic          timeout_err,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued_count
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_IMM   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [16:0]   mem [DEPTH];
  logic [2:0]    state;
  logic [AW:0]   pc_q;
  logic [AW:0]   len_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   din_q;
  logic          run_q;
  logic          terr_q;

  logic [AW:0]   len_clamped;
  logic [AW:0]   pc_step;
  logic [16:0]   cur_entry;
  logic [AW-1:0] imm_addr;

  assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign cur_entry   = mem[pc_q[AW-1:0]];
  // Explicit wrap keeps the immediate fetch correct for non-power-of-two depths.
  assign imm_addr    = (pc_q[AW-1:0] == AW'(DEPTH - 1)) ? '0 : pc_q[AW-1:0] + AW'(1);
  assign pc_step     = pc_q + (cur_entry[16] ? (AW+1)'(2) : (AW+1)'(1));

  assign busy         = (state == S_ISSUE) || (state == S_IMM) ||
                        (state == S_WAIT)  || (state == S_GAP);
  assign halted       = (state == S_HALT);
  assign DIN          = din_q;
  assign Run          = run_q;
  assign timeout_err  = terr_q;
  assign pc           = pc_q[AW-1:0];
  assign issued_count = count_q;

  // Program memory is frozen while a sequence runs so the replay stays repeatable.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      count_q  <= '0;
      wait_cnt <= '0;
      din_q    <= '0;
      run_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      run_q <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_q    <= '0;
            count_q <= '0;
            terr_q  <= 1'b0;
            len_q   <= len_clamped;
            if (len_clamped != '0) begin
              state <= S_ISSUE;
              run_q <= 1'b1;
              din_q <= mem[0][15:0];
            end else begin
              state <= S_HALT;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          if (cur_entry[16]) begin
            state <= S_IMM;
            din_q <= mem[imm_addr][15:0];
          end else begin
            state <= S_WAIT;
          end
        end
        S_IMM: state <= S_WAIT;
        S_WAIT: begin
          if (Done) begin
            count_q <= count_q + (AW+1)'(1);
            pc_q    <= pc_step;
            state   <= (pc_step >= len_q) ? S_HALT : S_GAP;
          end else if (wait_cnt == CNT_LAST) begin
            state  <= S_HALT;
            terr_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_GAP: begin
          state <= S_ISSUE;
          run_q <= 1'b1;
          din_q <= cur_entry[15:0];
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
